// File: rtl/meio_subtrator_core.sv
// ============================================================================
// Module     : meio_subtrator_core
// Description: Registered half subtractor. S = (A - B) mod 2^WIDTH, C = (A < B),
//              qualified by out_valid one clock after in_valid.
//              Optional borrow statistics counter: define MEIO_SUBTRATOR_STATS_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module meio_subtrator_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
`ifdef MEIO_SUBTRATOR_STATS_EN
    output logic [15:0]      borrow_count,
`endif
    output logic             C
);

    // One extra bit on the subtraction exposes the borrow as the MSB.
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;

    assign w_diff   = {1'b0, A} - {1'b0, B};
    assign w_borrow = w_diff[WIDTH];

    // Operands are only consumed under in_valid, so X/Z on an idle bus never
    // reaches the held result.
    always_comb begin
        s_d = s_q;
        c_d = c_q;
        if (in_valid) begin
            s_d = w_diff[WIDTH-1:0];
            c_d = w_borrow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            s_q         <= s_d;
            c_q         <= c_d;
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign C         = c_q;

`ifdef MEIO_SUBTRATOR_STATS_EN
    logic [15:0] borrow_count_q, borrow_count_d;

    // Saturating count of accepted operations that produced a borrow.
    always_comb begin
        borrow_count_d = borrow_count_q;
        if (in_valid && w_borrow && (borrow_count_q != 16'hFFFF)) begin
            borrow_count_d = borrow_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow_count_q <= '0;
        end else begin
            borrow_count_q <= borrow_count_d;
        end
    end

    assign borrow_count = borrow_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_meio_subtrator_core.sv
// ============================================================================
// Module     : tb_meio_subtrator_core
// Description: Self-checking bench for meio_subtrator_core, WIDTH=1 and WIDTH=8.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_meio_subtrator_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;
    logic       ov1, ov8, c1, c8;
    logic [0:0] s1;
    logic [7:0] s8;
`ifdef MEIO_SUBTRATOR_STATS_EN
    logic [15:0] bc1, bc8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    meio_subtrator_core #(.WIDTH(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .A            (a1),
        .B            (b1),
        .out_valid    (ov1),
        .S            (s1),
`ifdef MEIO_SUBTRATOR_STATS_EN
        .borrow_count (bc1),
`endif
        .C            (c1)
    );

    meio_subtrator_core #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .A            (a8),
        .B            (b8),
        .out_valid    (ov8),
        .S            (s8),
`ifdef MEIO_SUBTRATOR_STATS_EN
        .borrow_count (bc8),
`endif
        .C            (c8)
    );

    typedef struct {
        logic [0:0] a1, b1, s1;
        logic       c1;
        logic [7:0] a8, b8, s8;
        logic       c8;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ov, input logic [0:0] es1, input logic ec1,
                             input logic [7:0] es8, input logic ec8);
        check({tag, " w1.out_valid"}, {31'd0, ov1}, {31'd0, ov});
        check({tag, " w1.S"},         {31'd0, s1},  {31'd0, es1});
        check({tag, " w1.C"},         {31'd0, c1},  {31'd0, ec1});
        check({tag, " w8.out_valid"}, {31'd0, ov8}, {31'd0, ov});
        check({tag, " w8.S"},         {24'd0, s8},  {24'd0, es8});
        check({tag, " w8.C"},         {31'd0, c8},  {31'd0, ec8});
    endtask

    task automatic apply(input logic [0:0] ia1, input logic [0:0] ib1, input logic [7:0] ia8, input logic [7:0] ib8);
        in_valid = 1'b1;
        a1 = ia1; b1 = ib1; a8 = ia8; b8 = ib8;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            a1    b1    s1    c1    a8      b8      s8      c8
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd3,   8'd5,   8'hFE,  1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd200, 8'd55,  8'd145, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0,   8'd0,   1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd0,   8'd255, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd255, 8'd1,   1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd128, 8'd128, 8'd0,   1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1,   8'd2,   8'hFF,  1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd127, 8'd128, 8'hFF,  1'b1};

        rst_n = 1'b0; in_valid = 1'b0;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back valids: one result per edge, one cycle latency.
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].a1, vecs[i].b1, vecs[i].a8, vecs[i].b8);
            check_all($sformatf("vec%0d", i), 1'b1, vecs[i].s1, vecs[i].c1, vecs[i].s8, vecs[i].c8);
        end

        // Idle with undriven operands: results hold, out_valid drops.
        in_valid = 1'b0;
        a1 = 'x; b1 = 'x; a8 = 'x; b8 = 'x;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
        end

        // Asynchronous reset between edges while a result is valid.
        apply(1'b0, 1'b1, 8'd3, 8'd5);
        check_all("pre_rst", 1'b1, 1'b1, 1'b1, 8'hFE, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release captures.
        apply(1'b1, 1'b0, 8'd200, 8'd55);
        check_all("post_rst", 1'b1, 1'b1, 1'b0, 8'd145, 1'b0);

`ifdef MEIO_SUBTRATOR_STATS_EN
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("stats.reset", {16'd0, bc8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 8'd3,   8'd5);
        apply(1'b0, 1'b0, 8'd200, 8'd55);
        apply(1'b0, 1'b0, 8'd0,   8'd255);
        apply(1'b0, 1'b0, 8'd9,   8'd1);
        check("stats.count2", {16'd0, bc8}, 32'd2);
        in_valid = 1'b1; a8 = 8'd0; b8 = 8'd1;
        repeat (65537) @(posedge clk);
        #1;
        check("stats.saturate", {16'd0, bc8}, 32'h0000FFFF);
        in_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
